// File: rtl/axi_burst_arbiter_if.sv
`default_nettype none
// axi_burst_arbiter_if: AXI bus bundle between the burst arbiter (master) and the interconnect (slave).
// Revision: 1.0
interface axi_burst_arbiter_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_burst_arbiter.sv
`default_nettype none
// axi_burst_arbiter: N-channel round-robin AXI master, independent read/write paths, one burst each.
// Optional macro RAW_HAZARD_CHECK_EN holds back reads that hit the line of an in-flight write. Revision: 1.0
module axi_burst_arbiter #(
  parameter int NUM_CH        = 3,
  parameter int ID_W          = 4,
  parameter int LINE_OFFSET_W = 5
) (
  input  wire                   aclk,
  input  wire                   rst,
  input  wire  [NUM_CH-1:0]     ch_rreq,
  input  wire  [NUM_CH*32-1:0]  ch_raddr,
  input  wire  [NUM_CH*8-1:0]   ch_rlen,
  output logic [NUM_CH-1:0]     ch_racc,
  output logic [31:0]           ch_rdata,
  output logic [NUM_CH-1:0]     ch_rvalid,
  output logic [NUM_CH-1:0]     ch_rlast,
  input  wire  [NUM_CH-1:0]     ch_wreq,
  input  wire  [NUM_CH*32-1:0]  ch_waddr,
  input  wire  [NUM_CH*8-1:0]   ch_wlen,
  input  wire  [NUM_CH*32-1:0]  ch_wdata,
  input  wire  [NUM_CH*4-1:0]   ch_wstrb,
  output logic [NUM_CH-1:0]     ch_wacc,
  output logic [NUM_CH-1:0]     ch_wready,
  output logic [NUM_CH-1:0]     ch_bvalid,
  axi_burst_arbiter_if.master   axi
);
  localparam int CH_W = $clog2(NUM_CH);
  typedef logic [CH_W-1:0] ch_idx_t;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_e;

  // Returns {found, index}: first set bit of req at or after ptr, wrapping modulo NUM_CH.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req, input ch_idx_t ptr);
    logic [CH_W:0] res;
    int            idx;
    ch_idx_t       c;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      c = ch_idx_t'(idx);
      if (req[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  function automatic ch_idx_t rr_next(input ch_idx_t g);
    return (g == ch_idx_t'(NUM_CH - 1)) ? '0 : g + ch_idx_t'(1);
  endfunction

  rd_state_e     r_state_q, r_state_d;
  ch_idx_t       rr_r_q, rr_r_d, r_ch_q, r_ch_d;
  logic [31:0]   r_addr_q, r_addr_d;
  logic [7:0]    r_len_q, r_len_d;
  logic [CH_W:0] r_pick;
  logic [NUM_CH-1:0] r_elig;
  logic          r_ready;

  wr_state_e     w_state_q, w_state_d;
  ch_idx_t       rr_w_q, rr_w_d, w_ch_q, w_ch_d;
  logic [31:0]   w_addr_q, w_addr_d;
  logic [7:0]    w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [CH_W:0] w_pick;
  logic          w_valid, w_last, b_ready;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;

`ifdef RAW_HAZARD_CHECK_EN
  // A dirty-line writeback must land before a refill of the same line is issued.
  always_comb begin
    r_elig = ch_rreq;
    if (w_state_q != W_IDLE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_raddr[32*i+LINE_OFFSET_W +: 32-LINE_OFFSET_W] == w_addr_q[31:LINE_OFFSET_W])
          r_elig[i] = 1'b0;
      end
    end
  end
`else
  assign r_elig = ch_rreq;
`endif

  always_comb begin
    r_state_d = r_state_q;
    rr_r_d    = rr_r_q;
    r_ch_d    = r_ch_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    ch_racc   = '0;
    ch_rvalid = '0;
    ch_rlast  = '0;
    ch_rdata  = '0;
    r_ready   = 1'b0;
    r_pick    = rr_pick(r_elig, rr_r_q);
    unique case (r_state_q)
      R_IDLE: begin
        if (r_pick[CH_W] && !rst) begin
          ch_racc[r_pick[CH_W-1:0]] = 1'b1;
          r_ch_d    = r_pick[CH_W-1:0];
          r_addr_d  = ch_raddr[32*r_pick[CH_W-1:0] +: 32];
          r_len_d   = ch_rlen[8*r_pick[CH_W-1:0] +: 8];
          rr_r_d    = rr_next(r_pick[CH_W-1:0]);
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: if (axi.arready) r_state_d = R_DATA;
      R_DATA: begin
        r_ready = 1'b1;
        if (axi.rvalid) begin
          ch_rdata          = axi.rdata;
          ch_rvalid[r_ch_q] = 1'b1;
          ch_rlast[r_ch_q]  = axi.rlast;
          if (axi.rlast) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    rr_w_d    = rr_w_q;
    w_ch_d    = w_ch_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    ch_wacc   = '0;
    ch_wready = '0;
    ch_bvalid = '0;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    w_data    = '0;
    w_strb    = '0;
    b_ready   = 1'b0;
    w_pick    = rr_pick(ch_wreq, rr_w_q);
    unique case (w_state_q)
      W_IDLE: begin
        if (w_pick[CH_W] && !rst) begin
          ch_wacc[w_pick[CH_W-1:0]] = 1'b1;
          w_ch_d    = w_pick[CH_W-1:0];
          w_addr_d  = ch_waddr[32*w_pick[CH_W-1:0] +: 32];
          w_len_d   = ch_wlen[8*w_pick[CH_W-1:0] +: 8];
          w_cnt_d   = '0;
          rr_w_d    = rr_next(w_pick[CH_W-1:0]);
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: if (axi.awready) w_state_d = W_DATA;
      W_DATA: begin
        w_valid = 1'b1;
        w_data  = ch_wdata[32*w_ch_q +: 32];
        w_strb  = ch_wstrb[4*w_ch_q +: 4];
        w_last  = (w_cnt_q == w_len_q);
        if (axi.wready) begin
          ch_wready[w_ch_q] = 1'b1;
          // The counter stops at len, so len=255 never wraps before the last beat.
          if (w_last) begin
            w_cnt_d   = '0;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        b_ready = 1'b1;
        if (axi.bvalid) begin
          ch_bvalid[w_ch_q] = 1'b1;
          w_state_d         = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rr_r_q    <= '0;
      r_ch_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      w_state_q <= W_IDLE;
      rr_w_q    <= '0;
      w_ch_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rr_r_q    <= rr_r_d;
      r_ch_q    <= r_ch_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      w_state_q <= w_state_d;
      rr_w_q    <= rr_w_d;
      w_ch_q    <= w_ch_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  assign axi.arid    = ID_W'(r_ch_q);
  assign axi.araddr  = r_addr_q;
  assign axi.arlen   = r_len_q;
  assign axi.arvalid = (r_state_q == R_ADDR);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.rready  = r_ready;

  assign axi.awid    = ID_W'(w_ch_q);
  assign axi.awaddr  = w_addr_q;
  assign axi.awlen   = w_len_q;
  assign axi.awvalid = (w_state_q == W_ADDR);
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.wid     = ID_W'(w_ch_q);
  assign axi.wdata   = w_data;
  assign axi.wstrb   = w_strb;
  assign axi.wlast   = w_last;
  assign axi.wvalid  = w_valid;
  assign axi.bready  = b_ready;

  // IDs and response codes carry no information with a single outstanding burst per direction.
  logic unused_axi_ok;
  assign unused_axi_ok = ^{axi.rid, axi.rresp, axi.bid, axi.bresp} | (LINE_OFFSET_W == 0);
endmodule
`default_nettype wire

// File: tb/tb_axi_burst_arbiter.sv
`default_nettype none
// tb_axi_burst_arbiter: random channel and slave traffic compared each cycle with a transaction-level model.
// Revision: 1.0
module tb_axi_burst_arbiter;
  localparam int NUM_CH = 3;
  localparam int ID_W   = 4;
  localparam int LO     = 5;
`ifdef RAW_HAZARD_CHECK_EN
  localparam bit HAZARD = 1'b1;
`else
  localparam bit HAZARD = 1'b0;
`endif

  logic aclk = 1'b0;
  logic rst;
  always #5 aclk = ~aclk;

  logic [NUM_CH-1:0]    ch_rreq, ch_racc, ch_rvalid, ch_rlast;
  logic [NUM_CH-1:0]    ch_wreq, ch_wacc, ch_wready, ch_bvalid;
  logic [NUM_CH*32-1:0] ch_raddr, ch_waddr, ch_wdata;
  logic [NUM_CH*8-1:0]  ch_rlen, ch_wlen;
  logic [NUM_CH*4-1:0]  ch_wstrb;
  logic [31:0]          ch_rdata;

  axi_burst_arbiter_if #(.ID_W(ID_W)) axi ();

  axi_burst_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W), .LINE_OFFSET_W(LO)) dut (
    .aclk(aclk), .rst(rst),
    .ch_rreq(ch_rreq), .ch_raddr(ch_raddr), .ch_rlen(ch_rlen), .ch_racc(ch_racc),
    .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid), .ch_rlast(ch_rlast),
    .ch_wreq(ch_wreq), .ch_waddr(ch_waddr), .ch_wlen(ch_wlen), .ch_wdata(ch_wdata),
    .ch_wstrb(ch_wstrb), .ch_wacc(ch_wacc), .ch_wready(ch_wready), .ch_bvalid(ch_bvalid),
    .axi(axi)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Channel-side request state and in-flight bookkeeping.
  bit          rq[NUM_CH], wq[NUM_CH], r_infl[NUM_CH], w_infl[NUM_CH];
  logic [31:0] rq_addr[NUM_CH], wq_addr[NUM_CH];
  int          rq_len[NUM_CH], wq_len[NUM_CH];
  logic [31:0] wbeat_data[NUM_CH][256];
  logic [3:0]  wbeat_strb[NUM_CH][256];

  // Transaction-level view of each direction.
  int          rr_ptr, wr_ptr;
  bit          r_busy, r_ar, r_dat;
  int          r_own, r_len, r_cnt;
  logic [31:0] r_addr;
  bit          w_busy, w_aw, w_dat, w_rsp;
  int          w_own, w_len, w_cnt;
  logic [31:0] w_addr;

  function automatic logic [NUM_CH-1:0] onehot(input int c);
    logic [NUM_CH-1:0] v;
    v = '0;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  function automatic bit rd_eligible(input int c);
    if (!rq[c]) return 1'b0;
    if (HAZARD && w_busy && rq_addr[c][31:LO] == w_addr[31:LO]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int first_from(input int ptr, input bit wr);
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (ptr + k) % NUM_CH;
      if (wr ? wq[c] : rd_eligible(c)) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 3) == 0) ? 32'h1FC0_0000 : 32'h0000_1000;
    return base + 32'($urandom_range(0, 3)) * 32 + 32'($urandom_range(0, 7)) * 4;
  endfunction

  function automatic int rand_len();
    int x;
    x = int'($urandom_range(0, 59));
    if (x == 0) return 255;
    if (x < 6) return 0;
    return int'($urandom_range(1, 7));
  endfunction

  task automatic new_write(input int c, input int len);
    wq[c] = 1'b1;
    wq_addr[c] = rand_addr();
    wq_len[c] = len;
    for (int b = 0; b <= len; b++) begin
      wbeat_data[c][b] = $urandom;
      wbeat_strb[c][b] = 4'($urandom);
    end
  endtask

  task automatic reset_model();
    rr_ptr = 0; wr_ptr = 0;
    r_busy = 0; r_ar = 0; r_dat = 0; r_own = 0; r_len = 0; r_cnt = 0; r_addr = '0;
    w_busy = 0; w_aw = 0; w_dat = 0; w_rsp = 0; w_own = 0; w_len = 0; w_cnt = 0; w_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rq[c] = 0; wq[c] = 0; r_infl[c] = 0; w_infl[c] = 0;
      rq_addr[c] = '0; wq_addr[c] = '0; rq_len[c] = 0; wq_len[c] = 0;
      wbeat_data[c][0] = '0; wbeat_strb[c][0] = '0;
    end
  endtask

  task automatic drive_inputs(input bit quiet);
    for (int c = 0; c < NUM_CH; c++) begin
      int beat;
      if (!quiet) begin
        if (!rq[c] && !r_infl[c] && $urandom_range(0, 3) == 0) begin
          rq[c] = 1'b1; rq_addr[c] = rand_addr(); rq_len[c] = rand_len();
        end else if (rq[c] && $urandom_range(0, 19) == 0) begin
          rq[c] = 1'b0;
        end
        if (!wq[c] && !w_infl[c] && $urandom_range(0, 5) == 0) new_write(c, rand_len());
        else if (wq[c] && $urandom_range(0, 19) == 0) wq[c] = 1'b0;
      end
      beat = (w_dat && w_own == c) ? w_cnt : 0;
      ch_rreq[c]             = rq[c];
      ch_raddr[32*c +: 32]   = rq_addr[c];
      ch_rlen[8*c +: 8]      = 8'(rq_len[c]);
      ch_wreq[c]             = wq[c];
      ch_waddr[32*c +: 32]   = wq_addr[c];
      ch_wlen[8*c +: 8]      = 8'(wq_len[c]);
      ch_wdata[32*c +: 32]   = wbeat_data[c][beat];
      ch_wstrb[4*c +: 4]     = wbeat_strb[c][beat];
    end
    axi.arready = ($urandom_range(0, 2) == 0);
    axi.rvalid  = r_dat && ($urandom_range(0, 2) != 0);
    axi.rdata   = $urandom;
    axi.rlast   = axi.rvalid && (r_cnt == r_len);
    axi.rid     = ID_W'(r_own);
    axi.rresp   = 2'b00;
    axi.awready = ($urandom_range(0, 1) == 0);
    axi.wready  = ($urandom_range(0, 1) == 0);
    axi.bvalid  = w_rsp && ($urandom_range(0, 2) == 0);
    axi.bid     = ID_W'(w_own);
    axi.bresp   = 2'b00;
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, "_racc"},   ch_racc,     '0);
    check({ph, "_rvalid"}, ch_rvalid,   '0);
    check({ph, "_rlast"},  ch_rlast,    '0);
    check({ph, "_rdata"},  ch_rdata,    '0);
    check({ph, "_wacc"},   ch_wacc,     '0);
    check({ph, "_wready"}, ch_wready,   '0);
    check({ph, "_bvalid"}, ch_bvalid,   '0);
    check({ph, "_arvalid"}, axi.arvalid, '0);
    check({ph, "_araddr"}, axi.araddr,  '0);
    check({ph, "_rready"}, axi.rready,  '0);
    check({ph, "_awvalid"}, axi.awvalid, '0);
    check({ph, "_wvalid"}, axi.wvalid,  '0);
    check({ph, "_wdata"},  axi.wdata,   '0);
    check({ph, "_wlast"},  axi.wlast,   '0);
    check({ph, "_bready"}, axi.bready,  '0);
  endtask

  task automatic step();
    int rg, wg;
    logic [NUM_CH-1:0] e;
    @(negedge aclk);
    drive_inputs(1'b0);
    #1;
    rg = r_busy ? -1 : first_from(rr_ptr, 1'b0);
    wg = w_busy ? -1 : first_from(wr_ptr, 1'b1);

    check("ch_racc", ch_racc, onehot(rg));
    check("arvalid", axi.arvalid, r_ar);
    if (r_ar) begin
      check("araddr", axi.araddr, r_addr);
      check("arlen", axi.arlen, r_len);
      check("arid", axi.arid, r_own);
    end
    check("rready", axi.rready, r_dat);
    e = (r_dat && axi.rvalid) ? onehot(r_own) : '0;
    check("ch_rvalid", ch_rvalid, e);
    check("ch_rlast", ch_rlast, axi.rlast ? e : '0);
    if (e != '0) check("ch_rdata", ch_rdata, axi.rdata);

    check("ch_wacc", ch_wacc, onehot(wg));
    check("awvalid", axi.awvalid, w_aw);
    if (w_aw) begin
      check("awaddr", axi.awaddr, w_addr);
      check("awlen", axi.awlen, w_len);
      check("awid", axi.awid, w_own);
    end
    check("wvalid", axi.wvalid, w_dat);
    if (w_dat) begin
      check("wdata", axi.wdata, wbeat_data[w_own][w_cnt]);
      check("wstrb", axi.wstrb, wbeat_strb[w_own][w_cnt]);
      check("wid", axi.wid, w_own);
      check("wlast", axi.wlast, w_cnt == w_len);
    end
    e = (w_dat && axi.wready) ? onehot(w_own) : '0;
    check("ch_wready", ch_wready, e);
    check("bready", axi.bready, w_rsp);
    e = (w_rsp && axi.bvalid) ? onehot(w_own) : '0;
    check("ch_bvalid", ch_bvalid, e);

    if (rg >= 0) begin
      r_busy = 1; r_ar = 1; r_own = rg; r_addr = rq_addr[rg]; r_len = rq_len[rg];
      rr_ptr = (rg + 1) % NUM_CH; rq[rg] = 0; r_infl[rg] = 1;
    end else if (r_ar) begin
      if (axi.arready) begin r_ar = 0; r_dat = 1; r_cnt = 0; end
    end else if (r_dat && axi.rvalid) begin
      if (r_cnt == r_len) begin r_dat = 0; r_busy = 0; r_infl[r_own] = 0; end
      else r_cnt++;
    end

    if (wg >= 0) begin
      w_busy = 1; w_aw = 1; w_own = wg; w_addr = wq_addr[wg]; w_len = wq_len[wg];
      wr_ptr = (wg + 1) % NUM_CH; wq[wg] = 0; w_infl[wg] = 1;
    end else if (w_aw) begin
      if (axi.awready) begin w_aw = 0; w_dat = 1; w_cnt = 0; end
    end else if (w_dat) begin
      if (axi.wready) begin
        if (w_cnt == w_len) begin w_dat = 0; w_rsp = 1; end
        else w_cnt++;
      end
    end else if (w_rsp && axi.bvalid) begin
      w_rsp = 0; w_busy = 0; w_infl[w_own] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset_model();
    rst = 1'b1;
    drive_inputs(1'b1);
    repeat (3) @(posedge aclk);
    #1;
    check_all_zero("reset");
    check("arsize", axi.arsize, 3'b010);
    check("arburst", axi.arburst, 2'b01);
    check("awburst", axi.awburst, 2'b01);

    // All channels ask for a read, and the last channel starts a maximum-length write.
    for (int c = 0; c < NUM_CH; c++) begin
      rq[c] = 1'b1; rq_addr[c] = rand_addr(); rq_len[c] = 3;
    end
    new_write(NUM_CH - 1, 255);
    @(negedge aclk);
    rst = 1'b0;
    repeat (4000) step();

    guard = 0;
    while (!(r_dat && r_cnt == 2 && r_len >= 3) && guard < 5000) begin
      step();
      guard++;
    end
    check("rst_wait", guard < 5000, 1'b1);

    // Reset lands while a data beat is on the bus.
    @(negedge aclk);
    drive_inputs(1'b0);
    axi.rvalid = 1'b1;
    axi.rlast  = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midburst");
    reset_model();
    drive_inputs(1'b1);
    repeat (2) @(negedge aclk);
    for (int c = 0; c < NUM_CH; c++) begin
      rq[c] = 1'b1; rq_addr[c] = rand_addr(); rq_len[c] = rand_len() % 8;
    end
    rst = 1'b0;
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_burst_arbiter.md
Name: axi_burst_arbiter

Overview:
- Parametrised N-channel AXI master arbiter placed between the cache subsystem (ICache, DCache, uncached path) and the AXI bus.
- Successor to the current single-client AXI interface.
- Read and write paths run independent round-robin arbiters, one outstanding burst per direction.
- Each burst is tagged with the channel index as the AXI ID. Returned beats and responses are steered back to the owning channel.

Parameters:
- NUM_CH, 3, number of cache-side channels (2..8)
- ID_W, 4, AXI ID width; NUM_CH must be ≤ 2^ID_W
- LINE_OFFSET_W, 5, byte-offset bits ignored by the hazard compare

Ports:
- aclk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ch_rreq  in  NUM_CH  read request; held until accepted
- ch_raddr  in  NUM_CH*32  read start address per channel
- ch_rlen  in  NUM_CH*8  read beats-1 per channel
- ch_racc  out  NUM_CH  one-cycle accept pulse
- ch_rdata  out  32  returned read data, shared by all channels
- ch_rvalid  out  NUM_CH  read beat valid for the owning channel
- ch_rlast  out  NUM_CH  final read beat for the owning channel
- ch_wreq  in  NUM_CH  write request; held until accepted
- ch_waddr  in  NUM_CH*32  write start address per channel
- ch_wlen  in  NUM_CH*8  write beats-1 per channel
- ch_wdata  in  NUM_CH*32  current write beat per channel
- ch_wstrb  in  NUM_CH*4  byte strobes per channel
- ch_wacc  out  NUM_CH  write accept pulse
- ch_wready  out  NUM_CH  current beat consumed; channel advances to the next beat
- ch_bvalid  out  NUM_CH  write response done
- arid/araddr/arlen/arvalid  out  ID_W/32/8/1  AXI read address; arready in 1
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI read data; rready out 1
- awid/awaddr/awlen/awvalid  out  ID_W/32/8/1  AXI write address; awready in 1
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1  AXI write data; wready in 1
- bid/bresp/bvalid  in  ID_W/2/1  AXI write response; bready out 1
- arsize/arburst/arlock/arcache/arprot, aw* equivalents  out  —  constants: 3'b010, 2'b01 (INCR), 0, 0, 0

Behaviour:
- Reset: every output is 0, both FSMs return to IDLE, and both round-robin pointers are 0. Reset mid-burst abandons the transaction with no further pulses.
- Read FSM: R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - R_IDLE: select the first requesting channel at or after rr_r, wrapping modulo NUM_CH.
  - On grant: pulse ch_racc[g], latch addr/len/g, set rr_r = (g+1) mod NUM_CH, go to R_ADDR. arvalid is high the cycle after the grant.
  - R_ADDR: hold arvalid/araddr/arlen/arid=g stable until arready. Then arvalid drops and the FSM goes to R_DATA.
  - R_DATA: rready=1. Each rvalid beat drives ch_rdata=rdata and ch_rvalid[g]=1 in the same cycle (combinational pass-through). ch_rlast[g]=rlast.
  - R_DATA exit: rvalid&rlast → R_IDLE; a new grant is possible the following cycle.
  - rid and rresp are not checked, since there is one outstanding read.
- Write FSM: W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: grant selection, ch_wacc pulse and rr_w update mirror the read side.
  - W_ADDR: awvalid held until awready.
  - W_DATA: wvalid=1, wdata/wstrb = channel g's inputs, wid=g.
    - 8-bit beat counter starts at 0.
    - wlast = (cnt == latched len).
    - ch_wready[g] = wvalid & wready; cnt increments on each such cycle.
    - wready & wlast → W_RESP.
  - W_RESP: bready=1. On bvalid, pulse ch_bvalid[g] for one cycle and go to W_IDLE.
- Read and write paths are fully concurrent; simultaneous grants in the same cycle are legal.
- A channel whose request drops before grant is skipped; no grant is issued to a non-requesting channel.
- len=0 gives single-beat transfers (wlast on the first beat). len=255 is the maximum; the counter must not wrap before wlast.
- Pointer wrap: after a grant to NUM_CH-1, the pointer becomes 0.

Optional Feature:
- Macro: RAW_HAZARD_CHECK_EN.
- Defined: in R_IDLE, a candidate read is masked while the write FSM is not in W_IDLE and raddr[31:LINE_OFFSET_W] equals the latched waddr[31:LINE_OFFSET_W].
  - The round-robin then moves to the next eligible channel.
  - The masked read is granted in the cycle after the write FSM returns to W_IDLE.
  - This guarantees a dirty-line writeback completes before a refill of the same line.
- Undefined: no compare logic; reads are granted regardless of in-flight writes.

Test Plan:
- ch_rreq=3'b111, all slaves immediately ready, len=3 → grants in order 0,1,2; arid 0,1,2; 4 ch_rvalid beats each, ch_rlast on the 4th beat.
- Channel 1 read at 0x1FC0_0000 with len=7; arready delayed 5 cycles, rvalid gapped → araddr/arlen stable while waiting; exactly 8 ch_rvalid[1] pulses carry rdata; ch_rvalid[0] and ch_rvalid[2] stay 0.
- Channel 2 write with len=3, data 0xA0..0xA3, wready toggling every cycle → 4 ch_wready[2] pulses; wlast only with 0xA3; one ch_bvalid[2] after bvalid.
- Concurrent ch0 read and ch1 write issued in the same cycle → arvalid and awvalid both assert the next cycle; both complete independently.
- rst asserted during the 3rd beat of a len=7 read → all outputs 0 immediately; a request issued after reset is granted to channel 0 first.
- RAW_HAZARD_CHECK_EN defined: ch1 writeback to 0x0000_1040, then ch0 read of 0x0000_1050 → ch_racc[0] is withheld until the cycle after ch_bvalid[1]. Undefined: ch_racc[0] fires immediately.
